// File: rtl/bit_counter_param_pkg.sv
// State encoding shared by the bit-counter FSM and anything that observes it.
// The encoding is fixed so external tooling can decode a captured state value.
package bit_counter_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE  = 3'd0,
    ST_CHECK = 3'd1,
    ST_ADD   = 3'd2,
    ST_SHIFT = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

endpackage

// File: rtl/bit_counter_param_if.sv
// Request/result bundle between a bus front end (master) and the counter (slave).
interface bit_counter_param_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
);

  logic             init;
  logic             mode;
  logic [WIDTH-1:0] data_in;
  logic             abort;
  logic [CNT_W-1:0] count;
  logic             busy;
  logic             done;

  modport master (
    output init, mode, data_in, abort,
    input  count, busy, done
  );

  modport slave (
    input  init, mode, data_in, abort,
    output count, busy, done
  );

endinterface

// File: rtl/bit_counter_ctrl.sv
// Control FSM for the serial population counter: sequences load/add/shift and
// produces registered busy/done flags.
module bit_counter_ctrl
  import bit_counter_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic init,
  input  logic abort,
  input  logic a_zero,
  input  logic a0,
  output logic load,
  output logic add,
  output logic sft,
  output logic clr,
  output logic done,
  output logic busy
);

  state_t state_reg;
  logic   done_reg;
  logic   busy_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else if (abort && state_reg != ST_IDLE) begin
      // Abort wins over every transition, including the DONE exit.
      state_reg <= ST_IDLE;
      done_reg  <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (init && !abort) begin
            state_reg <= ST_CHECK;
            busy_reg  <= 1'b1;
          end
        end
        ST_CHECK: begin
          if (a_zero) begin
            state_reg <= ST_DONE;
            done_reg  <= 1'b1;
          end else if (a0) begin
            state_reg <= ST_ADD;
          end else begin
            state_reg <= ST_SHIFT;
          end
        end
        ST_ADD:   state_reg <= ST_SHIFT;
        ST_SHIFT: state_reg <= ST_CHECK;
        default: begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b0;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  // Datapath strobes act on the same edge as the transition they accompany.
  always_comb begin
    load = 1'b0;
    add  = 1'b0;
    sft  = 1'b0;
    clr  = 1'b0;
    if (state_reg == ST_IDLE) begin
      load = init && !abort;
    end else begin
      clr = abort;
      add = !abort && (state_reg == ST_ADD);
      sft = !abort && (state_reg == ST_SHIFT);
    end
  end

  assign done = done_reg;
  assign busy = busy_reg;

endmodule

// File: rtl/bit_counter_param.sv
// Serial population-count engine: counts ones (or zeros) of a loaded operand,
// stopping early once the shifted-down working operand reaches zero.
module bit_counter_param
  import bit_counter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  bit_counter_param_if.slave  bus
);

  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] a_load;
  logic [CNT_W-1:0] count_reg;
  logic             load;
  logic             add;
  logic             sft;
  logic             clr;

  // Counting zeros is counting ones of the inverted operand.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_load
      assign a_load[gi] = bus.data_in[gi] ^ bus.mode;
    end
  endgenerate

  bit_counter_ctrl u_ctrl (
    .clk    (clk),
    .rst_n  (rst_n),
    .init   (bus.init),
    .abort  (bus.abort),
    .a_zero (a_reg == '0),
    .a0     (a_reg[0]),
    .load   (load),
    .add    (add),
    .sft    (sft),
    .clr    (clr),
    .done   (bus.done),
    .busy   (bus.busy)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg     <= '0;
      count_reg <= '0;
    end else if (clr) begin
      a_reg     <= '0;
      count_reg <= '0;
    end else if (load) begin
      a_reg     <= a_load;
      count_reg <= '0;
    end else begin
      if (add) count_reg <= count_reg + CNT_W'(1);
      if (sft) a_reg <= a_reg >> 1;
    end
  end

  assign bus.count = count_reg;

endmodule

// File: tb/tb_bit_counter_param.sv
// Bench for bit_counter_param at WIDTH=8 and WIDTH=16: a popcount/latency model
// checked every cycle, plus directed operations with literal expectations.
module tb_bit_counter_param;

  logic clk;
  logic rst_n;

  bit_counter_param_if #(.WIDTH(8),  .CNT_W(4)) bus8 ();
  bit_counter_param_if #(.WIDTH(16), .CNT_W(5)) bus16 ();

  bit_counter_param #(.WIDTH(8), .CNT_W(4)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  bit_counter_param #(.WIDTH(16), .CNT_W(5)) dut16 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic        drv_init  [2];
  logic        drv_mode  [2];
  logic        drv_abort [2];
  logic [15:0] drv_data  [2];

  assign bus8.init     = drv_init[0];
  assign bus8.mode     = drv_mode[0];
  assign bus8.abort    = drv_abort[0];
  assign bus8.data_in  = drv_data[0][7:0];
  assign bus16.init    = drv_init[1];
  assign bus16.mode    = drv_mode[1];
  assign bus16.abort   = drv_abort[1];
  assign bus16.data_in = drv_data[1];

  logic [15:0] count_v [2];
  logic        busy_v  [2];
  logic        done_v  [2];

  assign count_v[0] = {12'd0, bus8.count};
  assign count_v[1] = {11'd0, bus16.count};
  assign busy_v[0]  = bus8.busy;
  assign busy_v[1]  = bus16.busy;
  assign done_v[0]  = bus8.done;
  assign done_v[1]  = bus16.done;

  function automatic logic [15:0] mask_of(input int i);
    return (i == 0) ? 16'h00FF : 16'hFFFF;
  endfunction

  function automatic logic [15:0] work_of(input int i, input logic [15:0] d, input logic m);
    return m ? (~d & mask_of(i)) : (d & mask_of(i));
  endfunction

  function automatic int popc(input logic [15:0] v);
    int n;
    n = 0;
    for (int b = 0; b < 16; b++) n += int'(v[b]);
    return n;
  endfunction

  function automatic int lat(input logic [15:0] v);
    int h;
    h = 0;
    if (v == 16'd0) return 2;
    for (int b = 0; b < 16; b++) if (v[b]) h = b;
    return 2 * h + popc(v) + 4;
  endfunction

  // Model: an accepted operation finishes after its formula latency; count is
  // only meaningful while idle or during the done pulse.
  logic exp_busy  [2];
  logic exp_done  [2];
  int   exp_count [2];
  int   pend      [2];
  int   rem       [2];

  always @(posedge clk or negedge rst_n) begin
    for (int i = 0; i < 2; i++) begin
      if (!rst_n) begin
        exp_busy[i]  <= 1'b0;
        exp_done[i]  <= 1'b0;
        exp_count[i] <= 0;
        pend[i]      <= 0;
        rem[i]       <= 0;
      end else if (!exp_busy[i]) begin
        if (drv_init[i] && !drv_abort[i]) begin
          pend[i]      <= popc(work_of(i, drv_data[i], drv_mode[i]));
          rem[i]       <= lat(work_of(i, drv_data[i], drv_mode[i])) - 1;
          exp_busy[i]  <= 1'b1;
          exp_count[i] <= 0;
        end
      end else if (drv_abort[i]) begin
        exp_busy[i]  <= 1'b0;
        exp_done[i]  <= 1'b0;
        exp_count[i] <= 0;
      end else if (exp_done[i]) begin
        exp_busy[i] <= 1'b0;
        exp_done[i] <= 1'b0;
      end else begin
        rem[i] <= rem[i] - 1;
        if (rem[i] == 1) begin
          exp_done[i]  <= 1'b1;
          exp_count[i] <= pend[i];
        end
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (busy_v[i] !== exp_busy[i]) begin
        errors++;
        $display("FAIL busy[%0d] t=%0t: got %b expected %b", i, $time, busy_v[i], exp_busy[i]);
      end
      checks++;
      if (done_v[i] !== exp_done[i]) begin
        errors++;
        $display("FAIL done[%0d] t=%0t: got %b expected %b", i, $time, done_v[i], exp_done[i]);
      end
      if (!exp_busy[i] || exp_done[i]) begin
        checks++;
        if (int'(count_v[i]) != exp_count[i] || $isunknown(count_v[i])) begin
          errors++;
          $display("FAIL count[%0d] t=%0t: got %0d expected %0d", i, $time, count_v[i], exp_count[i]);
        end
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Start an operation and measure edges from the init-sampling edge to DONE.
  // Optionally re-pulse init with other data while busy (must be ignored).
  task automatic run_op(input int i, input logic [15:0] d, input logic m,
                        input int exp_cnt, input int exp_edges,
                        input bit rep, input logic [15:0] rep_data);
    int  edges;
    bit  seen;
    seen = 0;
    @(negedge clk);
    drv_init[i] = 1'b1;
    drv_mode[i] = m;
    drv_data[i] = d;
    @(posedge clk);
    edges = 1;
    @(negedge clk);
    drv_init[i] = 1'b0;
    while (!seen && edges < 200) begin
      @(posedge clk);
      edges++;
      #1;
      if (done_v[i]) seen = 1;
      else if (rep && edges == 3) begin
        @(negedge clk);
        drv_init[i] = 1'b1;
        drv_data[i] = rep_data;
      end else if (rep && edges == 4) begin
        @(negedge clk);
        drv_init[i] = 1'b0;
      end
    end
    $display("op inst=%0d data=%h mode=%0d: count=%0d edges=%0d (exp %0d/%0d)",
             i, d, m, count_v[i], edges, exp_cnt, exp_edges);
    chk("done_seen", int'(seen), 1);
    chk("latency", edges, exp_edges);
    chk("result", int'(count_v[i]), exp_cnt);
    @(posedge clk);
  endtask

  task automatic abort_op(input int i, input logic [15:0] d, input int abort_edge);
    @(negedge clk);
    drv_init[i] = 1'b1;
    drv_mode[i] = 1'b0;
    drv_data[i] = d;
    @(posedge clk);
    @(negedge clk);
    drv_init[i] = 1'b0;
    repeat (abort_edge - 2) @(posedge clk);
    @(negedge clk);
    drv_abort[i] = 1'b1;
    @(posedge clk);
    #1;
    $display("abort inst=%0d data=%h: busy=%0d count=%0d done=%0d", i, d, busy_v[i], count_v[i], done_v[i]);
    chk("abort_busy", int'(busy_v[i]), 0);
    chk("abort_count", int'(count_v[i]), 0);
    chk("abort_done", int'(done_v[i]), 0);
    @(negedge clk);
    drv_abort[i] = 1'b0;
    repeat (30) @(posedge clk);
  endtask

  initial begin
    logic [15:0] d;
    logic        m;
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drv_init[i]  = 1'b0;
      drv_mode[i]  = 1'b0;
      drv_abort[i] = 1'b0;
      drv_data[i]  = 16'd0;
    end
    repeat (3) @(negedge clk);
    chk("reset_count", int'(count_v[0]), 0);
    chk("reset_busy", int'(busy_v[0]), 0);
    chk("reset_done", int'(done_v[1]), 0);
    #2 rst_n = 1'b1;

    // Reset in the middle of an operation (SHIFT after the first ADD).
    @(negedge clk);
    drv_init[0] = 1'b1;
    drv_data[0] = 16'h00FF;
    @(posedge clk);
    @(negedge clk);
    drv_init[0] = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("async reset mid-op: count=%0d busy=%0d done=%0d", count_v[0], busy_v[0], done_v[0]);
    chk("midop_rst_count", int'(count_v[0]), 0);
    chk("midop_rst_busy", int'(busy_v[0]), 0);
    chk("midop_rst_done", int'(done_v[0]), 0);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (30) @(posedge clk);

    run_op(0, 16'h0005, 1'b0, 2, 10, 0, 16'h0);
    run_op(0, 16'h00FF, 1'b1, 0, 2, 0, 16'h0);
    run_op(0, 16'h0000, 1'b1, 8, 26, 0, 16'h0);
    run_op(0, 16'h00FF, 1'b0, 8, 26, 0, 16'h0);

    abort_op(0, 16'h00F0, 5);
    run_op(0, 16'h0080, 1'b0, 1, 19, 0, 16'h0);
    abort_op(0, 16'h00FF, 5);

    run_op(0, 16'h0005, 1'b0, 2, 10, 1, 16'h00FF);

    // init together with abort in IDLE must not start anything.
    @(negedge clk);
    drv_init[0]  = 1'b1;
    drv_abort[0] = 1'b1;
    drv_data[0]  = 16'h00AA;
    @(posedge clk);
    #1;
    $display("init+abort idle: busy=%0d", busy_v[0]);
    chk("init_abort_busy", int'(busy_v[0]), 0);
    @(negedge clk);
    drv_init[0]  = 1'b0;
    drv_abort[0] = 1'b0;
    @(posedge clk);
    #1;
    chk("init_abort_busy2", int'(busy_v[0]), 0);

    run_op(1, 16'hFFFF, 1'b0, 16, 50, 0, 16'h0);
    run_op(1, 16'h0000, 1'b1, 16, 50, 0, 16'h0);
    run_op(1, 16'h8001, 1'b0, 2, 36, 0, 16'h0);

    for (int n = 0; n < 24; n++) begin
      int i;
      i = n % 2;
      d = 16'($urandom) & mask_of(i);
      m = 1'($urandom_range(0, 1));
      run_op(i, d, m, popc(work_of(i, d, m)), lat(work_of(i, d, m)), 0, 16'h0);
    end

    repeat (3) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
